// File: rtl/core_req_arbiter.sv
// Round-robin arbiter sharing one cache-core request/response port between
// NUM_REQ requesters, with one outstanding transaction and a response timeout.
module core_req_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 256,
   localparam int ID_W          = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
   localparam int STRB_W        = DATA_WIDTH / 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            rq_valid,
   output logic [NUM_REQ-1:0]            rq_ready,
   input  logic [NUM_REQ-1:0]            rq_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] rq_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] rq_wdata,
   input  logic [NUM_REQ*STRB_W-1:0]     rq_wstrb,
   output logic [NUM_REQ-1:0]            rs_valid,
   output logic                          rs_is_write,
   output logic [DATA_WIDTH-1:0]         rs_rdata,
   output logic [1:0]                    rs_resp,
   output logic                          core_req_valid,
   input  logic                          core_req_ready,
   output logic                          core_req_we,
   output logic [ADDR_WIDTH-1:0]         core_req_addr,
   output logic [DATA_WIDTH-1:0]         core_req_wdata,
   output logic [STRB_W-1:0]             core_req_wstrb,
   input  logic                          core_resp_valid,
   input  logic                          core_resp_is_write,
   input  logic [DATA_WIDTH-1:0]         core_resp_rdata,
   input  logic [1:0]                    core_resp_resp,
   output logic [ID_W-1:0]               grant_id,
   output logic                          err_timeout,
   output logic                          err_unexpected,
   output logic [1:0]                    dbg_state
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_RESP = 2'd2
   } state_t;

   localparam int CW      = ID_W + 1;
   localparam int CNT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam bit TO_EN   = (TIMEOUT_CYCLES > 0);

   state_t                state_q, state_d;
   logic [ID_W-1:0]       grant_q, grant_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0]     wstrb_q, wstrb_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [NUM_REQ-1:0]    rs_valid_q, rs_valid_d;
   logic                  rs_is_write_q, rs_is_write_d;
   logic [DATA_WIDTH-1:0] rs_rdata_q, rs_rdata_d;
   logic [1:0]            rs_resp_q, rs_resp_d;
   logic                  err_timeout_q, err_timeout_d;
   logic                  err_unexpected_q, err_unexpected_d;
   logic                  rs_fire;

   logic [ID_W-1:0]       win_id;
   logic                  win_found;
   logic [CW-1:0]         cand;

   // Scan from farthest to nearest so the nearest requester after the last
   // grant overwrites any earlier candidate.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      cand      = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = {1'b0, grant_q} + CW'(k);
         if (cand >= CW'(NUM_REQ)) begin
            cand = cand - CW'(NUM_REQ);
         end
         if (rq_valid[cand[ID_W-1:0]]) begin
            win_found = 1'b1;
            win_id    = cand[ID_W-1:0];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
         assign rq_ready[gi]   = (state_q == IDLE) && win_found && (win_id == ID_W'(gi));
         assign rs_valid_d[gi] = rs_fire && (grant_q == ID_W'(gi));
      end
   endgenerate

   always_comb begin
      state_d          = state_q;
      grant_d          = grant_q;
      we_d             = we_q;
      addr_d           = addr_q;
      wdata_d          = wdata_q;
      wstrb_d          = wstrb_q;
      cnt_d            = cnt_q;
      rs_fire          = 1'b0;
      rs_is_write_d    = rs_is_write_q;
      rs_rdata_d       = rs_rdata_q;
      rs_resp_d        = rs_resp_q;
      err_timeout_d    = err_timeout_q;
      err_unexpected_d = err_unexpected_q;
      case (state_q)
         IDLE: begin
            if (core_resp_valid) begin
               err_unexpected_d = 1'b1;
            end
            if (win_found) begin
               grant_d = win_id;
               we_d    = rq_we[win_id];
               addr_d  = rq_addr[win_id*ADDR_WIDTH +: ADDR_WIDTH];
               wdata_d = rq_wdata[win_id*DATA_WIDTH +: DATA_WIDTH];
               wstrb_d = rq_wstrb[win_id*STRB_W +: STRB_W];
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (core_resp_valid) begin
               err_unexpected_d = 1'b1;
            end
            if (core_req_ready) begin
               cnt_d   = '0;
               state_d = WAIT_RESP;
            end
         end
         WAIT_RESP: begin
            // A real response beats a timeout expiring in the same cycle.
            if (core_resp_valid) begin
               rs_fire       = 1'b1;
               rs_is_write_d = core_resp_is_write;
               rs_rdata_d    = core_resp_rdata;
               rs_resp_d     = core_resp_resp;
               if (core_resp_is_write != we_q) begin
                  err_unexpected_d = 1'b1;
               end
               state_d = IDLE;
            end else if (TO_EN && (cnt_q == CNT_W'(TO_LAST))) begin
               rs_fire       = 1'b1;
               rs_is_write_d = we_q;
               rs_rdata_d    = '0;
               rs_resp_d     = 2'b10;
               err_timeout_d = 1'b1;
               state_d       = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         grant_q          <= ID_W'(NUM_REQ - 1);
         we_q             <= 1'b0;
         addr_q           <= '0;
         wdata_q          <= '0;
         wstrb_q          <= '0;
         cnt_q            <= '0;
         rs_valid_q       <= '0;
         rs_is_write_q    <= 1'b0;
         rs_rdata_q       <= '0;
         rs_resp_q        <= '0;
         err_timeout_q    <= 1'b0;
         err_unexpected_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         grant_q          <= grant_d;
         we_q             <= we_d;
         addr_q           <= addr_d;
         wdata_q          <= wdata_d;
         wstrb_q          <= wstrb_d;
         cnt_q            <= cnt_d;
         rs_valid_q       <= rs_valid_d;
         rs_is_write_q    <= rs_is_write_d;
         rs_rdata_q       <= rs_rdata_d;
         rs_resp_q        <= rs_resp_d;
         err_timeout_q    <= err_timeout_d;
         err_unexpected_q <= err_unexpected_d;
      end
   end

   assign core_req_valid = (state_q == ISSUE);
   assign core_req_we    = we_q;
   assign core_req_addr  = addr_q;
   assign core_req_wdata = wdata_q;
   assign core_req_wstrb = wstrb_q;
   assign rs_valid       = rs_valid_q;
   assign rs_is_write    = rs_is_write_q;
   assign rs_rdata       = rs_rdata_q;
   assign rs_resp        = rs_resp_q;
   assign grant_id       = grant_q;
   assign err_timeout    = err_timeout_q;
   assign err_unexpected = err_unexpected_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_core_req_arbiter.sv
// Directed plus randomized bench for core_req_arbiter; a transaction-level
// model predicts grants, forwarded fields, responses and sticky error flags.
module tb_core_req_arbiter;

   localparam int NREQ = 2;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int SW   = DW / 8;
   localparam int TO   = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      rq_valid, rq_ready, rq_we, rs_valid;
   logic [NREQ*AW-1:0]   rq_addr;
   logic [NREQ*DW-1:0]   rq_wdata;
   logic [NREQ*SW-1:0]   rq_wstrb;
   logic                 rs_is_write;
   logic [DW-1:0]        rs_rdata;
   logic [1:0]           rs_resp;
   logic                 core_req_valid, core_req_ready, core_req_we;
   logic [AW-1:0]        core_req_addr;
   logic [DW-1:0]        core_req_wdata;
   logic [SW-1:0]        core_req_wstrb;
   logic                 core_resp_valid, core_resp_is_write;
   logic [DW-1:0]        core_resp_rdata;
   logic [1:0]           core_resp_resp;
   logic [0:0]           grant_id;
   logic                 err_timeout, err_unexpected;
   logic [1:0]           dbg_state;

   core_req_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NREQ), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_we(rq_we),
      .rq_addr(rq_addr), .rq_wdata(rq_wdata), .rq_wstrb(rq_wstrb),
      .rs_valid(rs_valid), .rs_is_write(rs_is_write), .rs_rdata(rs_rdata), .rs_resp(rs_resp),
      .core_req_valid(core_req_valid), .core_req_ready(core_req_ready), .core_req_we(core_req_we),
      .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata), .core_req_wstrb(core_req_wstrb),
      .core_resp_valid(core_resp_valid), .core_resp_is_write(core_resp_is_write),
      .core_resp_rdata(core_resp_rdata), .core_resp_resp(core_resp_resp),
      .grant_id(grant_id), .err_timeout(err_timeout), .err_unexpected(err_unexpected),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Model state: pending requests per requester, last grant, sticky flags
   bit          pend [NREQ];
   logic        p_we [NREQ];
   logic [31:0] p_addr [NREQ];
   logic [31:0] p_wdata [NREQ];
   logic [3:0]  p_wstrb [NREQ];
   int          last;
   bit          exp_to, exp_unexp;
   int          n_chk, n_fail;

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         rq_valid[i]            = pend[i];
         rq_we[i]               = p_we[i];
         rq_addr[i*AW +: AW]    = p_addr[i];
         rq_wdata[i*DW +: DW]   = p_wdata[i];
         rq_wstrb[i*SW +: SW]   = p_wstrb[i];
      end
   endtask

   task automatic fill(input int i);
      pend[i]    = 1'b1;
      p_we[i]    = 1'($urandom_range(0, 1));
      p_addr[i]  = $urandom;
      p_wdata[i] = $urandom;
      p_wstrb[i] = 4'($urandom_range(0, 15));
   endtask

   // Round-robin rule: first pending requester after the last grant, with wrap.
   function automatic int rr_pick(input int prev);
      for (int k = 1; k <= NREQ; k++) begin
         if (pend[(prev + k) % NREQ]) return (prev + k) % NREQ;
      end
      return -1;
   endfunction

   // Entered in an IDLE cycle with requests driven and settled; returns in the
   // cycle the response pulse is visible (FSM back in IDLE).
   task automatic txn(input int w, input int rd, input int rp, input logic mis,
                      input logic [31:0] rdat, input logic [1:0] rcode);
      logic [NREQ-1:0] oh;
      oh = '0;
      oh[w] = 1'b1;
      $display("txn req%0d we=%0d addr=%08h wdata=%08h rdy_dly=%0d resp_dly=%0d mis=%0d",
               w, p_we[w], p_addr[w], p_wdata[w], rd, rp, mis);
      chk("arb_ready", rq_ready, oh);
      next();
      pend[w] = 1'b0;
      drive();
      #1;
      chk("grant_id", grant_id, w);
      last = w;
      for (int c = 0; c <= rd; c++) begin
         if (c == rd) core_req_ready = 1'b1;
         chk("issue_valid", core_req_valid, 1'b1);
         chk("issue_we", core_req_we, p_we[w]);
         chk("issue_addr", core_req_addr, p_addr[w]);
         chk("issue_wdata", core_req_wdata, p_wdata[w]);
         chk("issue_wstrb", core_req_wstrb, p_wstrb[w]);
         chk("issue_rq_ready", rq_ready, '0);
         next();
      end
      core_req_ready = 1'b0;
      for (int c = 0; c < ((rp >= TO) ? TO : rp); c++) begin
         chk("wait_state", dbg_state, 2'd2);
         chk("wait_rs_valid", rs_valid, '0);
         chk("wait_req_valid", core_req_valid, 1'b0);
         chk("wait_rq_ready", rq_ready, '0);
         next();
      end
      if (rp < TO) begin
         core_resp_valid    = 1'b1;
         core_resp_is_write = p_we[w] ^ mis;
         core_resp_rdata    = rdat;
         core_resp_resp     = rcode;
         next();
         core_resp_valid = 1'b0;
         if (mis) exp_unexp = 1'b1;
         chk("rs_valid", rs_valid, oh);
         chk("rs_rdata", rs_rdata, rdat);
         chk("rs_resp", rs_resp, rcode);
         chk("rs_is_write", rs_is_write, p_we[w] ^ mis);
      end else begin
         exp_to = 1'b1;
         chk("to_rs_valid", rs_valid, oh);
         chk("to_rs_rdata", rs_rdata, 32'h0);
         chk("to_rs_resp", rs_resp, 2'b10);
         chk("to_rs_is_write", rs_is_write, p_we[w]);
      end
      chk("err_timeout", err_timeout, exp_to);
      chk("err_unexpected", err_unexpected, exp_unexp);
      chk("back_idle", dbg_state, 2'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      n_chk = 0; n_fail = 0; exp_to = 0; exp_unexp = 0; last = NREQ - 1;
      for (int i = 0; i < NREQ; i++) begin
         pend[i] = 0; p_we[i] = 0; p_addr[i] = 0; p_wdata[i] = 0; p_wstrb[i] = 0;
      end
      rst = 1'b1; core_req_ready = 0; core_resp_valid = 0; core_resp_is_write = 0;
      core_resp_rdata = 0; core_resp_resp = 0;
      drive();
      next();
      next();
      rst = 1'b0;
      chk("rst_state", dbg_state, 2'd0);
      chk("rst_grant", grant_id, NREQ - 1);
      chk("rst_rs_valid", rs_valid, '0);
      chk("rst_rs_rdata", rs_rdata, 32'h0);
      chk("rst_req_valid", core_req_valid, 1'b0);
      chk("rst_req_addr", core_req_addr, 32'h0);
      chk("rst_errs", {err_timeout, err_unexpected}, 2'b00);
      chk("rst_rq_ready", rq_ready, '0);

      // Round-robin: both requesters valid continuously
      for (int g = 0; g < 4; g++) begin
         if (g < 3) for (int i = 0; i < NREQ; i++) if (!pend[i]) fill(i);
         drive();
         #1;
         w = rr_pick(last);
         txn(w, 0, 0, 1'b0, $urandom, 2'b00);
      end

      // Single read request
      pend[0] = 1; p_we[0] = 0; p_addr[0] = 32'h10; p_wdata[0] = 0; p_wstrb[0] = 0;
      drive();
      #1;
      txn(rr_pick(last), 0, 1, 1'b0, 32'h12345678, 2'b00);
      next();
      chk("pulse_width", rs_valid, '0);
      chk("rs_hold", rs_rdata, 32'h12345678);

      // Backpressure on a write while the other requester waits
      fill(0);
      pend[1] = 1; p_we[1] = 1; p_addr[1] = 32'h0; p_wdata[1] = 32'hDEADBEEF; p_wstrb[1] = 4'hF;
      drive();
      #1;
      txn(rr_pick(last), 5, 0, 1'b0, 32'h0, 2'b00);

      // Response on the expiry cycle wins over the timeout
      txn(rr_pick(last), 0, TO - 1, 1'b0, 32'hCAFEF00D, 2'b00);

      // Timeout, then a late response is dropped
      fill(1);
      drive();
      #1;
      txn(rr_pick(last), 0, 20, 1'b0, 32'h0, 2'b00);
      core_resp_valid = 1'b1;
      next();
      core_resp_valid = 1'b0;
      exp_unexp = 1'b1;
      chk("late_unexpected", err_unexpected, 1'b1);
      chk("late_rs_valid", rs_valid, '0);
      chk("late_state", dbg_state, 2'd0);

      // Reset during WAIT_RESP
      fill(0);
      drive();
      #1;
      chk("mid_ready", rq_ready, 2'b01);
      next();
      pend[0] = 0;
      drive();
      core_req_ready = 1'b1;
      next();
      core_req_ready = 1'b0;
      next();
      chk("mid_in_wait", dbg_state, 2'd2);
      rst = 1'b1;
      next();
      rst = 1'b0;
      exp_to = 0; exp_unexp = 0; last = NREQ - 1;
      chk("mid_rst_state", dbg_state, 2'd0);
      chk("mid_rst_grant", grant_id, NREQ - 1);
      chk("mid_rst_errs", {err_timeout, err_unexpected}, 2'b00);
      for (int c = 0; c < 3; c++) begin
         chk("mid_no_pulse", rs_valid, '0);
         next();
      end
      fill(0);
      fill(1);
      drive();
      #1;
      txn(rr_pick(last), 0, 0, 1'b0, $urandom, 2'b00);

      // Randomized traffic
      for (int t = 0; t < 60; t++) begin
         for (int i = 0; i < NREQ; i++) if (!pend[i] && $urandom_range(0, 3) != 0) fill(i);
         if (rr_pick(last) < 0) fill(int'($urandom_range(0, NREQ - 1)));
         drive();
         #1;
         txn(rr_pick(last), int'($urandom_range(0, 3)), int'($urandom_range(0, 9)),
             ($urandom_range(0, 7) == 0), $urandom, 2'($urandom_range(0, 3)));
      end

      next();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/core_req_arbiter.md
Name: core_req_arbiter

Overview:
- Round-robin arbiter that shares one cache-core request/response port between NUM_REQ requesters (e.g. CPU-side AXI4-Lite translator plus a DMA/debug translator).
- Allows exactly one outstanding core transaction at a time.
- Routes each core response back to the requester that issued it.
- Synthesises an error response if the core never answers.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.
- NUM_REQ, 2, number of requesters (≥2).
- TIMEOUT_CYCLES, 256, maximum cycles in WAIT_RESP before a synthetic SLVERR; 0 disables the timeout.
- ID_W = max(1, clog2(NUM_REQ)) is derived, not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rq_valid  in  NUM_REQ  per-requester request valid
- rq_ready  out  NUM_REQ  per-requester request accept
- rq_we  in  NUM_REQ  per-requester write enable
- rq_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- rq_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- rq_wstrb  in  NUM_REQ*DATA_WIDTH/8  packed write strobes
- rs_valid  out  NUM_REQ  per-requester response valid, 1-cycle pulse
- rs_is_write  out  1  response type (shared bus)
- rs_rdata  out  DATA_WIDTH  response read data (shared bus)
- rs_resp  out  2  response code (shared bus)
- core_req_valid  out  1  core request valid
- core_req_ready  in  1  core request accept
- core_req_we  out  1  core write enable
- core_req_addr  out  ADDR_WIDTH  core address
- core_req_wdata  out  DATA_WIDTH  core write data
- core_req_wstrb  out  DATA_WIDTH/8  core write strobes
- core_resp_valid  in  1  core response valid
- core_resp_is_write  in  1  core response type
- core_resp_rdata  in  DATA_WIDTH  core read data
- core_resp_resp  in  2  core response code
- grant_id  out  ID_W  index of the current/last granted requester
- err_timeout  out  1  sticky: a timeout fired
- err_unexpected  out  1  sticky: a core response arrived outside WAIT_RESP, or with is_write ≠ latched we
- dbg_state  out  2  FSM state: IDLE=0, ISSUE=1, WAIT_RESP=2

Behaviour:
- Reset values: all outputs 0 except grant_id = NUM_REQ-1; FSM = IDLE; rr pointer = NUM_REQ-1; timeout counter = 0. Reset asserted mid-transaction aborts it silently; no rs_valid is generated.
- IDLE:
  - Winner = first i with rq_valid[i], searching from (rr_ptr+1) mod NUM_REQ upward with wrap.
  - rq_ready[winner] = 1 combinationally in the same cycle; all other rq_ready bits are 0.
  - On that handshake: latch we/addr/wdata/wstrb and the winner id; rr_ptr ← grant_id ← winner; go to ISSUE.
  - No rq_valid: stay in IDLE.
- rq_ready is 0 in every state other than IDLE; requesters must hold request fields stable until accepted.
- ISSUE:
  - core_req_valid = 1 with the latched fields, driven from registers.
  - On core_req_ready: go to WAIT_RESP and clear the timeout counter.
  - Fields stay stable while core_req_ready = 0.
- core_req_valid is 0 in IDLE and WAIT_RESP.
- WAIT_RESP, normal response:
  - On core_resp_valid, register is_write/rdata/resp into rs_*.
  - Pulse rs_valid[grant] for exactly one cycle, the next cycle.
  - Go to IDLE.
  - If core_resp_is_write ≠ latched we: still forward, and set err_unexpected.
- WAIT_RESP, timeout:
  - The counter increments every cycle without core_resp_valid.
  - When it reaches TIMEOUT_CYCLES-1 with no response: next cycle rs_valid[grant] = 1, rs_resp = 2'b10, rs_rdata = 0, rs_is_write = latched we; set err_timeout; go to IDLE.
  - A response arriving in the same cycle as expiry wins: it is forwarded normally and err_timeout is not set.
- core_resp_valid in IDLE or ISSUE is dropped and sets err_unexpected; this covers late responses after a timeout.
- rs_is_write/rs_rdata/rs_resp hold their last value when no rs_valid bit is high.
- Latency:
  - Accept at cycle T → core_req_valid from T+1.
  - core_resp_valid at R → rs_valid at R+1; the FSM is in IDLE at R+1, so the next accept is possible at R+1.
  - Minimum 3 cycles per transaction.
- Fairness: a requester holding rq_valid high waits at most NUM_REQ-1 transactions.

Test Plan:
- Single request: req0 rd addr 0x10, core_req_ready=1, core responds rdata 0x12345678 two cycles after issue → core_req_valid 1 cycle after accept; rs_valid[0] one cycle after core_resp_valid; rs_rdata=0x12345678, rs_resp=0.
- Round-robin: req0 and req1 both valid continuously from reset, each core response 1 cycle after issue → grant order 0,1,0,1; never two consecutive grants to the same requester.
- Backpressure: core_req_ready held 0 for 5 cycles on a write of 0xDEADBEEF, wstrb 0xF, addr 0x0 → core_req_valid stays 1 with stable fields for 5 cycles; rq_ready all 0 throughout.
- Timeout: TIMEOUT_CYCLES=8, no core response → exactly 8 cycles in WAIT_RESP, then rs_valid[grant] with rs_resp=2'b10, rdata=0; err_timeout=1; a later core_resp_valid is dropped and err_unexpected=1.
- Same-cycle expiry: core_resp_valid arrives on the expiry cycle → normal forward, resp=0, err_timeout stays 0.
- Reset mid-WAIT_RESP: assert rst for 1 cycle → dbg_state=0, no rs_valid pulse, next grant goes to requester 0.
